// File: rtl/red_pitaya_iq_sweep_ctrl.sv
// Frequency-sweep scheduler for the IQ fgen: resync, settle, dwell and step through N points,
// configured over the PS register bus and driving phase increment, fgen enable and acquire gate.
module red_pitaya_iq_sweep_ctrl #(
  parameter int unsigned PHASEBITS = 32,
  parameter int unsigned CNTBITS   = 32,
  parameter int unsigned IDXBITS   = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [15:0]          addr,
  input  logic                 wen,
  input  logic                 ren,
  input  logic [31:0]          wdata,
  output logic                 ack,
  output logic [31:0]          rdata,
  output logic [PHASEBITS-1:0] phase_inc_o,
  output logic [PHASEBITS-1:0] shift_phase_o,
  output logic                 fgen_on_o,
  output logic                 acq_en_o,
  output logic                 point_done_o,
  output logic                 sweep_done_o,
  output logic [IDXBITS-1:0]   point_idx_o,
  output logic                 busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_SETTLE, S_DWELL, S_STEP, S_DONE
  } state_t;

  localparam logic [15:0] A_CTRL   = 16'h0100;
  localparam logic [15:0] A_FSTART = 16'h0104;
  localparam logic [15:0] A_FSTEP  = 16'h0108;
  localparam logic [15:0] A_NPTS   = 16'h010C;
  localparam logic [15:0] A_SETTLE = 16'h0110;
  localparam logic [15:0] A_DWELL  = 16'h0114;
  localparam logic [15:0] A_SHIFT  = 16'h0118;
  localparam logic [15:0] A_STATUS = 16'h011C;
  localparam logic [15:0] A_PBITS  = 16'h0200;
  localparam logic [15:0] A_CBITS  = 16'h0204;
  localparam logic [15:0] A_IBITS  = 16'h0208;

  // Bus-visible configuration
  logic                 cont_q;
  logic [PHASEBITS-1:0] f_start_q, f_step_q, shift_q;
  logic [IDXBITS-1:0]   n_points_q;
  logic [CNTBITS-1:0]   settle_q, dwell_q;

  // Shadow copies used by the running sweep
  logic [PHASEBITS-1:0] sh_f_start, sh_f_step;
  logic [IDXBITS-1:0]   sh_n;
  logic [CNTBITS-1:0]   sh_settle, sh_dwell;

  state_t               state_q, state_nxt;
  logic [CNTBITS-1:0]   cnt_q, cnt_nxt;
  logic                 done_flag_q, done_flag_nxt;
  logic [PHASEBITS-1:0] phase_nxt;
  logic [IDXBITS-1:0]   idx_nxt;
  logic                 fgen_on_nxt, acq_nxt, pdone_nxt, sdone_nxt, busy_nxt;
  logic                 load_shadow_c;

  logic                 start_c, abort_c;
  logic [31:0]          rdata_c;
  logic [CNTBITS-1:0]   dwell_last_c;
  state_t               first_c;

  assign start_c      = wen && (addr == A_CTRL) && wdata[0];
  assign abort_c      = wen && (addr == A_CTRL) && wdata[1];
  assign dwell_last_c = (sh_dwell == '0) ? '0 : sh_dwell - CNTBITS'(1);
  assign first_c      = (sh_settle == '0) ? S_DWELL : S_SETTLE;

  // Register file writes
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cont_q     <= 1'b0;
      f_start_q  <= '0;
      f_step_q   <= '0;
      n_points_q <= '0;
      settle_q   <= '0;
      dwell_q    <= '0;
      shift_q    <= '0;
    end else if (wen) begin
      case (addr)
        A_CTRL:   cont_q     <= wdata[2];
        A_FSTART: f_start_q  <= PHASEBITS'(wdata);
        A_FSTEP:  f_step_q   <= PHASEBITS'(wdata);
        A_NPTS:   n_points_q <= IDXBITS'(wdata);
        A_SETTLE: settle_q   <= CNTBITS'(wdata);
        A_DWELL:  dwell_q    <= CNTBITS'(wdata);
        A_SHIFT:  shift_q    <= PHASEBITS'(wdata);
        default:  ;
      endcase
    end
  end

  // Read mux
  always_comb begin
    rdata_c = '0;
    case (addr)
      A_CTRL:   rdata_c = {29'd0, cont_q, 2'b00};
      A_FSTART: rdata_c = 32'(f_start_q);
      A_FSTEP:  rdata_c = 32'(f_step_q);
      A_NPTS:   rdata_c = 32'(n_points_q);
      A_SETTLE: rdata_c = 32'(settle_q);
      A_DWELL:  rdata_c = 32'(dwell_q);
      A_SHIFT:  rdata_c = 32'(shift_q);
      A_STATUS: rdata_c = {busy_o, done_flag_q, 14'd0, 16'(point_idx_o)};
      A_PBITS:  rdata_c = 32'(PHASEBITS);
      A_CBITS:  rdata_c = 32'(CNTBITS);
      A_IBITS:  rdata_c = 32'(IDXBITS);
      default:  rdata_c = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack <= wen | ren;
      if (ren) rdata <= rdata_c;
    end
  end

  // Next state, counters and output values
  always_comb begin
    state_nxt     = state_q;
    cnt_nxt       = cnt_q;
    phase_nxt     = phase_inc_o;
    idx_nxt       = point_idx_o;
    done_flag_nxt = done_flag_q;
    fgen_on_nxt   = 1'b1;
    acq_nxt       = 1'b0;
    pdone_nxt     = 1'b0;
    sdone_nxt     = 1'b0;
    load_shadow_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_c && (n_points_q != '0)) begin
          state_nxt     = S_SYNC;
          load_shadow_c = 1'b1;
        end
      end
      S_SYNC, S_STEP: begin
        state_nxt = first_c;
        cnt_nxt   = '0;
      end
      S_SETTLE: begin
        if (cnt_q == sh_settle - CNTBITS'(1)) begin
          state_nxt = S_DWELL;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + CNTBITS'(1);
        end
      end
      S_DWELL: begin
        if (cnt_q == dwell_last_c) begin
          state_nxt = (point_idx_o == sh_n - IDXBITS'(1)) ? S_DONE : S_STEP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + CNTBITS'(1);
        end
      end
      S_DONE:  state_nxt = cont_q ? S_SYNC : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    if (abort_c) begin
      state_nxt     = S_IDLE;
      cnt_nxt       = '0;
      load_shadow_c = 1'b0;
    end

    // Outputs are registered in step with the state they belong to
    case (state_nxt)
      S_SYNC: begin
        fgen_on_nxt   = 1'b0;
        phase_nxt     = (state_q == S_IDLE) ? f_start_q : sh_f_start;
        idx_nxt       = '0;
        done_flag_nxt = 1'b0;
      end
      S_DWELL: begin
        acq_nxt   = 1'b1;
        pdone_nxt = (cnt_nxt == dwell_last_c);
      end
      S_STEP: begin
        phase_nxt = phase_inc_o + sh_f_step;
        idx_nxt   = point_idx_o + IDXBITS'(1);
      end
      S_DONE: begin
        sdone_nxt     = 1'b1;
        done_flag_nxt = 1'b1;
      end
      default: ;
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      done_flag_q   <= 1'b0;
      phase_inc_o   <= '0;
      shift_phase_o <= '0;
      fgen_on_o     <= 1'b1;
      acq_en_o      <= 1'b0;
      point_done_o  <= 1'b0;
      sweep_done_o  <= 1'b0;
      point_idx_o   <= '0;
      busy_o        <= 1'b0;
      sh_f_start    <= '0;
      sh_f_step     <= '0;
      sh_n          <= '0;
      sh_settle     <= '0;
      sh_dwell      <= '0;
    end else begin
      state_q      <= state_nxt;
      cnt_q        <= cnt_nxt;
      done_flag_q  <= done_flag_nxt;
      phase_inc_o  <= phase_nxt;
      fgen_on_o    <= fgen_on_nxt;
      acq_en_o     <= acq_nxt;
      point_done_o <= pdone_nxt;
      sweep_done_o <= sdone_nxt;
      point_idx_o  <= idx_nxt;
      busy_o       <= busy_nxt;
      if (load_shadow_c) begin
        sh_f_start    <= f_start_q;
        sh_f_step     <= f_step_q;
        sh_n          <= n_points_q;
        sh_settle     <= settle_q;
        sh_dwell      <= dwell_q;
        shift_phase_o <= shift_q;
      end
    end
  end

endmodule

// File: tb/tb_red_pitaya_iq_sweep_ctrl.sv
// Scoreboard bench for the IQ sweep scheduler: bus reads, sync, point and sweep-done events.
module tb_red_pitaya_iq_sweep_ctrl;

  localparam logic [15:0] A_CTRL   = 16'h0100;
  localparam logic [15:0] A_FSTART = 16'h0104;
  localparam logic [15:0] A_FSTEP  = 16'h0108;
  localparam logic [15:0] A_NPTS   = 16'h010C;
  localparam logic [15:0] A_SETTLE = 16'h0110;
  localparam logic [15:0] A_DWELL  = 16'h0114;
  localparam logic [15:0] A_SHIFT  = 16'h0118;
  localparam logic [15:0] A_STATUS = 16'h011C;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] addr = '0;
  logic        wen = 1'b0, ren = 1'b0;
  logic [31:0] wdata = '0;
  logic        ack;
  logic [31:0] rdata;
  logic [31:0] phase_inc_o, shift_phase_o;
  logic        fgen_on_o, acq_en_o, point_done_o, sweep_done_o, busy_o;
  logic [15:0] point_idx_o;

  red_pitaya_iq_sweep_ctrl dut (
    .clk_i(clk), .rstn_i(rstn), .addr(addr), .wen(wen), .ren(ren), .wdata(wdata),
    .ack(ack), .rdata(rdata), .phase_inc_o(phase_inc_o), .shift_phase_o(shift_phase_o),
    .fgen_on_o(fgen_on_o), .acq_en_o(acq_en_o), .point_done_o(point_done_o),
    .sweep_done_o(sweep_done_o), .point_idx_o(point_idx_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          at;
    logic [31:0] phase;
    int          idx;
    int          acq;
  } ev_t;

  ev_t         exp_sync[$];
  ev_t         exp_pt[$];
  int          exp_sd[$];
  logic [31:0] exp_rd[$];

  int   checks = 0, failures = 0;
  int   cyc = 0;
  int   wr_cyc = 0;
  int   acq_run = 0;
  logic wen_d = 1'b0, ren_d = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    wen_d <= wen;
    ren_d <= ren;
  end

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin : mon
    ev_t e;
    if (rstn) begin
      if (acq_en_o) acq_run++;
      if (wen_d || ren_d) check("ack", 64'(ack), 64'd1);
      if (ren_d) begin
        check("rd_queued", 64'(exp_rd.size() != 0), 64'd1);
        if (exp_rd.size() != 0) check("rdata", 64'(rdata), 64'(exp_rd.pop_front()));
      end
      if (!fgen_on_o) begin
        check("sync_queued", 64'(exp_sync.size() != 0), 64'd1);
        if (exp_sync.size() != 0) begin
          e = exp_sync.pop_front();
          check("sync_cycle", 64'(cyc), 64'(e.at));
          check("sync_phase", 64'(phase_inc_o), 64'(e.phase));
          check("sync_idx", 64'(point_idx_o), 64'd0);
        end
      end
      if (point_done_o) begin
        check("pd_queued", 64'(exp_pt.size() != 0), 64'd1);
        if (exp_pt.size() != 0) begin
          e = exp_pt.pop_front();
          check("pd_cycle", 64'(cyc), 64'(e.at));
          check("pd_phase", 64'(phase_inc_o), 64'(e.phase));
          check("pd_idx", 64'(point_idx_o), 64'(e.idx));
          check("pd_acq_len", 64'(acq_run), 64'(e.acq));
        end
        acq_run = 0;
      end
      if (sweep_done_o) begin
        check("sd_queued", 64'(exp_sd.size() != 0), 64'd1);
        if (exp_sd.size() != 0) check("sd_cycle", 64'(cyc), 64'(exp_sd.pop_front()));
      end
      if (!busy_o) acq_run = 0;
    end
  end

  task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    addr = a; wdata = d; wen = 1'b1;
    @(posedge clk); #1;
    wr_cyc = cyc;
    wen = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a, input logic [31:0] exp);
    @(posedge clk); #1;
    addr = a; ren = 1'b1;
    exp_rd.push_back(exp);
    @(posedge clk); #1;
    ren = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy_o && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_reached", 64'(busy_o), 64'd0);
  endtask

  task automatic cfg(input logic [31:0] fs, input logic [31:0] fst, input int n,
                     input int st, input int dw);
    bus_wr(A_FSTART, fs);
    bus_wr(A_FSTEP, fst);
    bus_wr(A_NPTS, 32'(n));
    bus_wr(A_SETTLE, 32'(st));
    bus_wr(A_DWELL, 32'(dw));
  endtask

  // Expected events for a sweep whose SYNC cycle is s; only the first npush points are queued
  task automatic push_sweep(input logic [31:0] fs, input logic [31:0] fst, input int n,
                            input int st, input int dw, input int s, input int npush);
    int  d = (dw == 0) ? 1 : dw;
    int  p = st + d + 1;
    ev_t e;
    e.at = s; e.phase = fs; e.idx = 0; e.acq = 0;
    exp_sync.push_back(e);
    for (int k = 0; k < npush; k++) begin
      e.at = s + st + d + k * p;
      e.phase = fs + 32'(k) * fst;
      e.idx = k;
      e.acq = d;
      exp_pt.push_back(e);
    end
    if (npush == n) exp_sd.push_back(s + st + d + (n - 1) * p + 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_fgen_on"}, 64'(fgen_on_o), 64'd1);
    check({tag, "_phase"}, 64'(phase_inc_o), 64'd0);
    check({tag, "_shift"}, 64'(shift_phase_o), 64'd0);
    check({tag, "_acq"}, 64'(acq_en_o), 64'd0);
    check({tag, "_idx"}, 64'(point_idx_o), 64'd0);
    check({tag, "_pulses"}, 64'({point_done_o, sweep_done_o}), 64'd0);
  endtask

  initial begin : stim
    int s;
    // Reset values and register readback
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int a = 'h104; a <= 'h11C; a += 4) bus_rd(16'(a), 32'd0);
    bus_rd(16'h0208, 32'd16);
    bus_rd(16'h0200, 32'd32);
    bus_rd(16'h0204, 32'd32);
    bus_rd(16'h0300, 32'd0);

    // Basic 4-point sweep
    cfg(32'd1000, 32'd250, 4, 3, 5);
    bus_wr(A_SHIFT, 32'h4000_0000);
    bus_rd(A_FSTEP, 32'd250);
    bus_rd(A_DWELL, 32'd5);
    bus_wr(A_CTRL, 32'h1);
    push_sweep(32'd1000, 32'd250, 4, 3, 5, wr_cyc, 4);
    check("busy_after_start", 64'(busy_o), 64'd1);
    check("shift_latched", 64'(shift_phase_o), 64'h4000_0000);
    wait_idle(200);
    bus_rd(A_STATUS, 32'h4000_0003);
    check("phase_hold_idle", 64'(phase_inc_o), 64'd1750);

    // Phase increment wraps
    cfg(32'hFFFF_FF00, 32'h200, 2, 1, 2);
    bus_wr(A_CTRL, 32'h1);
    push_sweep(32'hFFFF_FF00, 32'h200, 2, 1, 2, wr_cyc, 2);
    wait_idle(100);
    check("wrap_phase", 64'(phase_inc_o), 64'h100);

    // Zero points: start ignored
    bus_wr(A_NPTS, 32'd0);
    bus_wr(A_CTRL, 32'h1);
    check("n0_busy", 64'(busy_o), 64'd0);
    repeat (5) @(posedge clk); #1;
    check("n0_busy_later", 64'(busy_o), 64'd0);
    bus_rd(A_STATUS, 32'h4000_0001);

    // Zero settle and dwell
    cfg(32'd77, 32'd3, 3, 0, 0);
    bus_wr(A_CTRL, 32'h1);
    push_sweep(32'd77, 32'd3, 3, 0, 0, wr_cyc, 3);
    wait_idle(100);

    // Abort during the second dwell
    cfg(32'd1000, 32'd250, 4, 3, 5);
    bus_wr(A_CTRL, 32'h1);
    s = wr_cyc;
    push_sweep(32'd1000, 32'd250, 4, 3, 5, s, 1);
    wait_until(s + 14);
    check("abort_pre_acq", 64'(acq_en_o), 64'd1);
    bus_wr(A_CTRL, 32'h2);
    check("abort_acq", 64'(acq_en_o), 64'd0);
    check("abort_busy", 64'(busy_o), 64'd0);
    repeat (30) @(posedge clk); #1;
    bus_rd(A_STATUS, 32'h0000_0001);
    bus_wr(A_CTRL, 32'h3);
    check("start_abort_busy", 64'(busy_o), 64'd0);
    repeat (3) @(posedge clk); #1;
    check("start_abort_busy_later", 64'(busy_o), 64'd0);

    // Continuous mode, mid-sweep config write deferred to next start
    cfg(32'd5000, 32'd100, 2, 2, 3);
    bus_wr(A_CTRL, 32'h5);
    s = wr_cyc;
    push_sweep(32'd5000, 32'd100, 2, 2, 3, s, 2);
    push_sweep(32'd5000, 32'd100, 2, 2, 3, s + 13, 2);
    push_sweep(32'd5000, 32'd100, 2, 2, 3, s + 26, 2);
    bus_rd(A_CTRL, 32'h4);
    bus_wr(A_FSTART, 32'd9999);
    wait_until(s + 29);
    bus_wr(A_CTRL, 32'h0);
    wait_until(s + 42);
    check("cont_stopped", 64'(busy_o), 64'd0);
    bus_rd(A_STATUS, 32'h4000_0001);
    bus_wr(A_CTRL, 32'h1);
    push_sweep(32'd9999, 32'd100, 2, 2, 3, wr_cyc, 2);
    wait_idle(100);

    // Reset mid-sweep
    bus_wr(A_CTRL, 32'h1);
    push_sweep(32'd9999, 32'd100, 2, 2, 3, wr_cyc, 0);
    repeat (3) @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rstn = 1'b1;
    bus_rd(A_FSTART, 32'd0);
    bus_rd(A_STATUS, 32'd0);
    repeat (5) @(posedge clk); #1;

    check("left_sync", 64'(exp_sync.size()), 64'd0);
    check("left_pt", 64'(exp_pt.size()), 64'd0);
    check("left_sd", 64'(exp_sd.size()), 64'd0);
    check("left_rd", 64'(exp_rd.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
